// File: rtl/anc_pkg.sv
// Shared types, widths and the DAC saturation helper for the ANC LMS sequencer.
package anc_pkg;

    localparam int SAMPLE_W = 16;
    localparam int DATA_W   = 32;

    localparam logic signed [DATA_W-1:0] SAT_MAX = 32'sd32767;
    localparam logic signed [DATA_W-1:0] SAT_MIN = -32'sd32768;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_OUTPUT
    } state_t;

    function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [DATA_W-1:0] x);
        logic signed [DATA_W-1:0] clamped;
        if (x > SAT_MAX) begin
            clamped = SAT_MAX;
        end else if (x < SAT_MIN) begin
            clamped = SAT_MIN;
        end else begin
            clamped = x;
        end
        return clamped[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/anc_lms_sequencer_if.sv
// FIR launch/result and DAC valid/ready signals between the sequencer and its neighbours.
interface anc_lms_sequencer_if;
    import anc_pkg::*;

    logic signed [DATA_W-1:0]   feedforward_out;
    logic signed [DATA_W-1:0]   weight_adjust;
    logic                       fir_go;
    logic signed [DATA_W-1:0]   fir_out_sample;
    logic                       fir_done;
    logic signed [SAMPLE_W-1:0] dac_out;
    logic                       dac_valid;
    logic                       dac_ready;

    modport master (
        output feedforward_out, weight_adjust, fir_go, dac_out, dac_valid,
        input  fir_out_sample, fir_done, dac_ready
    );

    modport slave (
        input  feedforward_out, weight_adjust, fir_go, dac_out, dac_valid,
        output fir_out_sample, fir_done, dac_ready
    );

endinterface

// File: rtl/anc_pair_buf.sv
// Reference/error sample slots with full flags; pairs them up and flags dropped samples.
module anc_pair_buf
    import anc_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [SAMPLE_W-1:0] ref_in,
    input  logic                       ref_valid,
    input  logic signed [SAMPLE_W-1:0] err_in,
    input  logic                       err_valid,
    input  logic                       pair_take,
    output logic                       pair_ready,
    output logic signed [SAMPLE_W-1:0] ref_q,
    output logic signed [SAMPLE_W-1:0] err_q,
    output logic                       overrun_evt
);

    logic ref_full;
    logic err_full;
    logic ref_open;
    logic err_open;

    // A slot being consumed this cycle can accept a new sample on the same edge.
    assign ref_open    = !ref_full || pair_take;
    assign err_open    = !err_full || pair_take;
    assign pair_ready  = ref_full && err_full;
    assign overrun_evt = (ref_valid && !ref_open) || (err_valid && !err_open);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data registers are reset along with the flags so the FIR never sees X operands.
            ref_full <= 1'b0;
            err_full <= 1'b0;
            ref_q    <= '0;
            err_q    <= '0;
        end else begin
            if (ref_valid && ref_open) begin
                ref_q    <= ref_in;
                ref_full <= 1'b1;
            end else if (pair_take) begin
                ref_full <= 1'b0;
            end

            if (err_valid && err_open) begin
                err_q    <= err_in;
                err_full <= 1'b1;
            end else if (pair_take) begin
                err_full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/anc_lms_sequencer.sv
// LMS sequencer: pairs ref/err samples, launches the FIR, saturates its result to the DAC.
// Optional ANC_ADAPT_FREEZE_EN adds adapt_freeze, which zeroes weight_adjust at launch.
module anc_lms_sequencer
    import anc_pkg::*;
#(
    parameter int TAPS        = 128,
    parameter int FRAC        = 15,
    parameter int WDOG_CYCLES = 2*TAPS+16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [SAMPLE_W-1:0] ref_in,
    input  logic                       ref_valid,
    input  logic signed [SAMPLE_W-1:0] err_in,
    input  logic                       err_valid,
    input  logic signed [SAMPLE_W-1:0] mu,
`ifdef ANC_ADAPT_FREEZE_EN
    input  logic                       adapt_freeze,
`endif
    anc_lms_sequencer_if.master        fir_dac,
    input  logic                       status_clr,
    output logic                       overrun,
    output logic                       fault
);

    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    state_t                     state;
    logic [WDOG_W-1:0]          wdog_cnt;
    logic                       pair_ready;
    logic                       pair_take;
    logic                       overrun_evt;
    logic signed [SAMPLE_W-1:0] ref_q;
    logic signed [SAMPLE_W-1:0] err_q;
    logic signed [DATA_W-1:0]   mu_x;
    logic signed [DATA_W-1:0]   err_x;
    logic signed [DATA_W-1:0]   step_prod;
    logic signed [DATA_W-1:0]   step_term;
    logic signed [DATA_W-1:0]   next_weight;

    logic signed [DATA_W-1:0]   feedforward_r;
    logic signed [DATA_W-1:0]   weight_r;
    logic                       fir_go_r;
    logic signed [SAMPLE_W-1:0] dac_out_r;
    logic                       dac_valid_r;

    assign pair_take = (state == ST_IDLE) && pair_ready && !dac_valid_r;

    anc_pair_buf u_pair_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .ref_in      (ref_in),
        .ref_valid   (ref_valid),
        .err_in      (err_in),
        .err_valid   (err_valid),
        .pair_take   (pair_take),
        .pair_ready  (pair_ready),
        .ref_q       (ref_q),
        .err_q       (err_q),
        .overrun_evt (overrun_evt)
    );

    // Step term is -floor(mu*err / 2^FRAC); the product always fits in 32 bits for mu >= 0.
    assign mu_x      = DATA_W'(mu);
    assign err_x     = DATA_W'(err_q);
    assign step_prod = mu_x * err_x;
    assign step_term = -(step_prod >>> FRAC);

`ifdef ANC_ADAPT_FREEZE_EN
    assign next_weight = adapt_freeze ? '0 : step_term;
`else
    assign next_weight = step_term;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            wdog_cnt      <= '0;
            feedforward_r <= '0;
            weight_r      <= '0;
            fir_go_r      <= 1'b0;
            dac_out_r     <= '0;
            dac_valid_r   <= 1'b0;
            overrun       <= 1'b0;
            fault         <= 1'b0;
        end else begin
            fir_go_r <= 1'b0;

            // NOTE: the clears are scheduled first so a later set in this block overrides them.
            if (status_clr) begin
                overrun <= 1'b0;
                fault   <= 1'b0;
            end
            if (overrun_evt) begin
                overrun <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (pair_take) begin
                        feedforward_r <= DATA_W'(ref_q);
                        weight_r      <= next_weight;
                        fir_go_r      <= 1'b1;
                        state         <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    wdog_cnt <= '0;
                    state    <= ST_RUN;
                end
                ST_RUN: begin
                    if (fir_dac.fir_done) begin
                        dac_out_r   <= sat16(fir_dac.fir_out_sample);
                        dac_valid_r <= 1'b1;
                        state       <= ST_OUTPUT;
                    end else if (wdog_cnt == WDOG_LAST) begin
                        fault <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        wdog_cnt <= wdog_cnt + 1'b1;
                    end
                end
                ST_OUTPUT: begin
                    if (fir_dac.dac_ready) begin
                        dac_valid_r <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign fir_dac.feedforward_out = feedforward_r;
    assign fir_dac.weight_adjust   = weight_r;
    assign fir_dac.fir_go          = fir_go_r;
    assign fir_dac.dac_out         = dac_out_r;
    assign fir_dac.dac_valid       = dac_valid_r;

endmodule

// File: tb/tb_anc_lms_sequencer.sv
// Directed bench for anc_lms_sequencer; freeze scenario runs only with ANC_ADAPT_FREEZE_EN.
module tb_anc_lms_sequencer;
    import anc_pkg::*;

    localparam int TAPS = 128;
    localparam int FRAC = 15;
    localparam int WDOG = 2*TAPS+16;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic signed [SAMPLE_W-1:0] ref_in = '0;
    logic                       ref_valid = 1'b0;
    logic signed [SAMPLE_W-1:0] err_in = '0;
    logic                       err_valid = 1'b0;
    logic signed [SAMPLE_W-1:0] mu = '0;
    logic                       status_clr = 1'b0;
    logic                       overrun;
    logic                       fault;
`ifdef ANC_ADAPT_FREEZE_EN
    logic                       adapt_freeze = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    anc_lms_sequencer_if sif ();

    anc_lms_sequencer #(
        .TAPS        (TAPS),
        .FRAC        (FRAC),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ref_in       (ref_in),
        .ref_valid    (ref_valid),
        .err_in       (err_in),
        .err_valid    (err_valid),
        .mu           (mu),
`ifdef ANC_ADAPT_FREEZE_EN
        .adapt_freeze (adapt_freeze),
`endif
        .fir_dac      (sif),
        .status_clr   (status_clr),
        .overrun      (overrun),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pair(input logic signed [SAMPLE_W-1:0] r, input logic signed [SAMPLE_W-1:0] e);
        ref_in = r;
        err_in = e;
        ref_valid = 1'b1;
        err_valid = 1'b1;
        tick();
        ref_valid = 1'b0;
        err_valid = 1'b0;
    endtask

    task automatic pulse_done(input logic signed [DATA_W-1:0] v);
        sif.fir_out_sample = v;
        sif.fir_done = 1'b1;
        tick();
        sif.fir_done = 1'b0;
    endtask

    task automatic handshake();
        sif.dac_ready = 1'b1;
        tick();
        sif.dac_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        n_checks++;
        if (sif.fir_go !== 1'b0 || sif.dac_valid !== 1'b0 || overrun !== 1'b0 || fault !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags: go=%b valid=%b ovr=%b fault=%b want all 0", sif.fir_go, sif.dac_valid, overrun, fault);
        end
        n_checks++;
        if (sif.feedforward_out !== 32'sd0 || sif.weight_adjust !== 32'sd0 || sif.dac_out !== 16'sd0) begin
            n_errors++;
            $display("FAIL reset_data: ff=%0d wa=%0d dac=%0d want 0", sif.feedforward_out, sif.weight_adjust, sif.dac_out);
        end
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_pair();
        mu = 16'sd3277;
        send_pair(16'sd1000, 16'sd16384);
        n_checks++;
        if (sif.fir_go !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_go_early: got %b want 0", sif.fir_go);
        end
        tick();
        n_checks++;
        if (sif.fir_go !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_go: got %b want 1", sif.fir_go);
        end
        n_checks++;
        if (sif.feedforward_out !== 32'sd1000 || sif.weight_adjust !== -32'sd1638) begin
            n_errors++;
            $display("FAIL basic_operands: ff=%0d wa=%0d want 1000 -1638", sif.feedforward_out, sif.weight_adjust);
        end
        tick();
        n_checks++;
        if (sif.fir_go !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_go_width: got %b want 0", sif.fir_go);
        end
        repeat (TAPS+1) tick();
        n_checks++;
        if (sif.dac_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_valid_early: got %b want 0", sif.dac_valid);
        end
        pulse_done(32'sd1234);
        n_checks++;
        if (sif.dac_valid !== 1'b1 || sif.dac_out !== 16'sd1234) begin
            n_errors++;
            $display("FAIL basic_output: valid=%b dac=%0d want 1 1234", sif.dac_valid, sif.dac_out);
        end
        n_checks++;
        if (sif.feedforward_out !== 32'sd1000 || sif.weight_adjust !== -32'sd1638) begin
            n_errors++;
            $display("FAIL basic_hold: ff=%0d wa=%0d want 1000 -1638", sif.feedforward_out, sif.weight_adjust);
        end
        handshake();
        n_checks++;
        if (sif.dac_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_accept: valid=%b want 0", sif.dac_valid);
        end
    endtask

    task automatic test_saturation();
        send_pair(-16'sd5, -16'sd16384);
        tick();
        n_checks++;
        if (sif.fir_go !== 1'b1 || sif.feedforward_out !== -32'sd5 || sif.weight_adjust !== 32'sd1639) begin
            n_errors++;
            $display("FAIL sat_operands: go=%b ff=%0d wa=%0d want 1 -5 1639", sif.fir_go, sif.feedforward_out, sif.weight_adjust);
        end
        repeat (4) tick();
        pulse_done(32'sd40000);
        n_checks++;
        if (sif.dac_out !== 16'sd32767) begin
            n_errors++;
            $display("FAIL sat_pos: got %0d want 32767", sif.dac_out);
        end
        handshake();
        send_pair(16'sd0, 16'sd0);
        tick();
        repeat (3) tick();
        pulse_done(-32'sd70000);
        n_checks++;
        if (sif.dac_out !== -16'sd32768) begin
            n_errors++;
            $display("FAIL sat_neg: got %0d want -32768", sif.dac_out);
        end
        handshake();
    endtask

    task automatic test_staggered_overrun();
        err_in = 16'sd100;
        err_valid = 1'b1;
        tick();
        err_valid = 1'b0;
        repeat (4) tick();
        ref_in = 16'sd200;
        ref_valid = 1'b1;
        tick();
        ref_valid = 1'b0;
        n_checks++;
        if (sif.fir_go !== 1'b0) begin
            n_errors++;
            $display("FAIL stag_go_early: got %b want 0", sif.fir_go);
        end
        tick();
        n_checks++;
        if (sif.fir_go !== 1'b1 || sif.feedforward_out !== 32'sd200 || sif.weight_adjust !== -32'sd10) begin
            n_errors++;
            $display("FAIL stag_launch: go=%b ff=%0d wa=%0d want 1 200 -10", sif.fir_go, sif.feedforward_out, sif.weight_adjust);
        end
        tick();
        err_in = 16'sd300;
        err_valid = 1'b1;
        tick();
        err_valid = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL stag_buffered: overrun=%b want 0", overrun);
        end
        err_in = 16'sd500;
        err_valid = 1'b1;
        status_clr = 1'b1;
        tick();
        err_valid = 1'b0;
        status_clr = 1'b0;
        n_checks++;
        if (overrun !== 1'b1) begin
            n_errors++;
            $display("FAIL stag_overrun_set_wins: overrun=%b want 1", overrun);
        end
        ref_in = 16'sd400;
        ref_valid = 1'b1;
        tick();
        ref_valid = 1'b0;
        pulse_done(32'sd77);
        n_checks++;
        if (sif.dac_valid !== 1'b1 || sif.dac_out !== 16'sd77) begin
            n_errors++;
            $display("FAIL stag_output: valid=%b dac=%0d want 1 77", sif.dac_valid, sif.dac_out);
        end
        handshake();
        n_checks++;
        if (sif.fir_go !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_go_early: got %b want 0", sif.fir_go);
        end
        tick();
        n_checks++;
        if (sif.fir_go !== 1'b1 || sif.feedforward_out !== 32'sd400 || sif.weight_adjust !== -32'sd30) begin
            n_errors++;
            $display("FAIL b2b_launch: go=%b ff=%0d wa=%0d want 1 400 -30", sif.fir_go, sif.feedforward_out, sif.weight_adjust);
        end
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL stag_clear: overrun=%b want 0", overrun);
        end
        tick();
        pulse_done(32'sd1);
        handshake();
    endtask

    task automatic test_backpressure();
        bit go_seen;
        bit out_moved;
        bit valid_lost;
        send_pair(16'sd10, 16'sd0);
        tick();
        tick();
        pulse_done(32'sd555);
        send_pair(16'sd7, 16'sd0);
        go_seen = 1'b0;
        out_moved = 1'b0;
        valid_lost = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (sif.fir_go) go_seen = 1'b1;
            if (sif.dac_out !== 16'sd555) out_moved = 1'b1;
            if (sif.dac_valid !== 1'b1) valid_lost = 1'b1;
        end
        n_checks++;
        if (go_seen !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_no_go: fir_go seen=%b want 0", go_seen);
        end
        n_checks++;
        if (out_moved !== 1'b0 || valid_lost !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_hold: dac_out moved=%b valid lost=%b want 0 0 (dac=%0d)", out_moved, valid_lost, sif.dac_out);
        end
        handshake();
        n_checks++;
        if (sif.dac_valid !== 1'b0 || sif.fir_go !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_release: valid=%b go=%b want 0 0", sif.dac_valid, sif.fir_go);
        end
        tick();
        n_checks++;
        if (sif.fir_go !== 1'b1 || sif.feedforward_out !== 32'sd7) begin
            n_errors++;
            $display("FAIL bp_launch: go=%b ff=%0d want 1 7", sif.fir_go, sif.feedforward_out);
        end
        tick();
        pulse_done(32'sd2);
        handshake();
    endtask

`ifdef ANC_ADAPT_FREEZE_EN
    task automatic test_freeze();
        adapt_freeze = 1'b1;
        send_pair(16'sd100, 16'sd16384);
        tick();
        adapt_freeze = 1'b0;
        n_checks++;
        if (sif.fir_go !== 1'b1 || sif.weight_adjust !== 32'sd0 || sif.feedforward_out !== 32'sd100) begin
            n_errors++;
            $display("FAIL freeze_launch: go=%b wa=%0d ff=%0d want 1 0 100", sif.fir_go, sif.weight_adjust, sif.feedforward_out);
        end
        tick();
        pulse_done(32'sd5);
        n_checks++;
        if (sif.dac_valid !== 1'b1 || sif.dac_out !== 16'sd5) begin
            n_errors++;
            $display("FAIL freeze_output: valid=%b dac=%0d want 1 5", sif.dac_valid, sif.dac_out);
        end
        handshake();
    endtask
`endif

    task automatic test_watchdog();
        bit go_seen;
        send_pair(16'sd1, 16'sd0);
        tick();
        n_checks++;
        if (sif.fir_go !== 1'b1) begin
            n_errors++;
            $display("FAIL wd_launch: go=%b want 1", sif.fir_go);
        end
        repeat (WDOG) tick();
        n_checks++;
        if (fault !== 1'b0) begin
            n_errors++;
            $display("FAIL wd_early: fault=%b want 0", fault);
        end
        tick();
        n_checks++;
        if (fault !== 1'b1 || sif.dac_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL wd_fault: fault=%b valid=%b want 1 0", fault, sif.dac_valid);
        end
        send_pair(16'sd2, 16'sd0);
        tick();
        n_checks++;
        if (sif.fir_go !== 1'b1 || sif.feedforward_out !== 32'sd2) begin
            n_errors++;
            $display("FAIL wd_back_to_idle: go=%b ff=%0d want 1 2", sif.fir_go, sif.feedforward_out);
        end
        err_in = 16'sd9;
        err_valid = 1'b1;
        tick();
        err_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (sif.feedforward_out !== 32'sd0 || fault !== 1'b0 || sif.fir_go !== 1'b0 || sif.dac_valid !== 1'b0 || overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_run: ff=%0d fault=%b go=%b valid=%b ovr=%b want all 0", sif.feedforward_out, fault, sif.fir_go, sif.dac_valid, overrun);
        end
        #2 rst_n = 1'b1;
        tick();
        ref_in = 16'sd3;
        ref_valid = 1'b1;
        tick();
        ref_valid = 1'b0;
        go_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (sif.fir_go) go_seen = 1'b1;
        end
        n_checks++;
        if (go_seen !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_slots_cleared: fir_go seen=%b want 0", go_seen);
        end
    endtask

    initial begin
        sif.fir_out_sample = '0;
        sif.fir_done = 1'b0;
        sif.dac_ready = 1'b0;
        test_reset();
        test_basic_pair();
        test_saturation();
        test_staggered_overrun();
        test_backpressure();
`ifdef ANC_ADAPT_FREEZE_EN
        test_freeze();
`endif
        test_watchdog();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/anc_lms_sequencer.md
# anc_lms_sequencer

Control stage directly upstream of the LMS FIR/weight-update engine in the ANC datapath. Pairs one reference-mic sample with one error-mic sample and forms the LMS step term. Launches one FIR run per pair and holds its operands stable for the whole run. Captures the FIR result, saturates it to the DAC width, and delivers it through a valid/ready handshake.

## Interface
- `TAPS`, 128: FIR length; sets the default watchdog bound.
- `FRAC`, 15: fractional bits of the Q-format; same value as the FIR stage.
- `WDOG_CYCLES`, 2*TAPS+16: maximum cycles from `fir_go` to `fir_done` before a fault is declared.
- `clk`  in  1: the only clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `ref_in`  in  16 signed: reference-mic sample, Q1.15.
- `ref_valid`  in  1: one-cycle strobe qualifying `ref_in`.
- `err_in`  in  16 signed: error-mic sample, Q1.15.
- `err_valid`  in  1: one-cycle strobe qualifying `err_in`.
- `mu`  in  16 signed: step size, Q1.15; must be ≥0; sampled when a pair completes.
- `feedforward_out`  out  32 signed: to FIR `feedforward_in`.
- `weight_adjust`  out  32 signed: to FIR weight-update input.
- `fir_go`  out  1: one-cycle start pulse to the FIR.
- `fir_out_sample`  in  32 signed: FIR result.
- `fir_done`  in  1: one-cycle completion pulse from the FIR.
- `dac_out`  out  16 signed: saturated anti-noise sample.
- `dac_valid`  out  1: `dac_out` is valid; held until accepted.
- `dac_ready`  in  1: downstream accepts when `dac_valid && dac_ready`.
- `overrun`  out  1: sticky; a sample was dropped.
- `fault`  out  1: sticky; watchdog expired.
- `status_clr`  in  1: clears `overrun` and `fault`.

## Operation
- **Pair buffer.** Separate ref and err slots, each a data register plus a full flag.
  - A strobe with its slot empty stores the sample and sets the flag.
  - A strobe with its slot full drops the new sample and sets `overrun`.
  - Slots accept samples in every FSM state, so the buffer is effectively double-buffered against a run in progress.
- **FSM: IDLE, LAUNCH, RUN, OUTPUT.**
  - **IDLE.** When both flags are set and `dac_valid` is 0, register the operands and go to LAUNCH:
    - `feedforward_out` = sign-extended ref.
    - `weight_adjust` = -((mu*err) >>> FRAC), where the product is 32-bit signed and the shift is arithmetic (floor).
    - Clear both flags.
  - **LAUNCH.** Assert `fir_go` for exactly one cycle, clear the watchdog counter, go to RUN.
  - **RUN.** Count cycles.
    - On `fir_done`: capture `sat16(fir_out_sample)` into `dac_out`, set `dac_valid`, go to OUTPUT.
    - If the count reaches `WDOG_CYCLES` first: set `fault`, go to IDLE, leave `dac_valid` at 0.
  - **OUTPUT.** On `dac_valid && dac_ready`: clear `dac_valid`, go to IDLE.
- `feedforward_out` and `weight_adjust` change only on the IDLE→LAUNCH transition. They stay constant through RUN because the FIR reads `weight_adjust` on every tap.
- `sat16`: clamp to [-32768, 32767].
- A `fir_done` seen outside RUN is ignored.

## Timing
- **Reset values.** All outputs 0; state IDLE; both flags cleared.
- **Reset mid-run.** Reset drops `fir_go` and `dac_valid` immediately and discards both pending slots.
- **Launch latency.** The pair completes at edge N; `fir_go` is high during cycle N+1, with operands already valid.
- **Output latency.** `dac_valid` rises the cycle after `fir_done`.
- **Slot filling.** A strobe and slot consumption in the same cycle: the slot is consumed, and the new sample fills the slot rather than counting as overrun.
- **Simultaneous status events.** If `status_clr` coincides with a new overrun or fault, the set wins.
- **Back-to-back pairs.** With a pair pending and `dac_ready` held high, the next `fir_go` follows the DAC handshake by 2 cycles (OUTPUT→IDLE→LAUNCH).

## Configuration
- `ANC_ADAPT_FREEZE_EN` defined:
  - Adds input `adapt_freeze` (1 bit).
  - If it is high on the IDLE→LAUNCH edge, `weight_adjust` is registered as 0; the FIR still runs and still produces output.
- `ANC_ADAPT_FREEZE_EN` undefined: the port does not exist and adaptation is always active.

## Structure
- **Shared package `anc_pkg`:**
  - FSM state enum.
  - `SAMPLE_W`=16 and `DATA_W`=32.
  - Saturation limits.
  - `sat16` function.
- **Sub-module `anc_pair_buf`:**
  - Contains the two slots, the flags and the overrun detection.
  - Outputs `pair_ready`, `ref_q`, `err_q`.
  - Input `pair_take`.

## Test plan
- **Basic pair.** Drive ref=1000, err=16384, mu=3277 in the same cycle → next cycle `fir_go`=1 with `feedforward_out`=1000 and `weight_adjust`=-1638. Model returns 1234 after TAPS+3 cycles → `dac_out`=1234 and `dac_valid`=1 the following cycle.
- **Saturation.** `fir_out_sample`=40000 → `dac_out`=32767; -70000 → -32768.
- **Staggered arrival and overrun.** err at t, ref at t+5 → launch at t+6. A second err during RUN is buffered. A third err before that pair launches → `overrun`=1, the third sample is dropped, and the buffered one launches next. `status_clr` then clears `overrun`.
- **Backpressure.** Hold `dac_ready`=0 for 50 cycles with a pair pending → no `fir_go` and `dac_out` stable. Release → `fir_go` 2 cycles after the handshake.
- **Watchdog.** Model never asserts done → `fault`=1 after `WDOG_CYCLES`, state returns to IDLE, no `dac_valid`. Async reset mid-RUN → all outputs 0 and flags cleared.
- **Freeze (macro on).** `adapt_freeze`=1 with err=16384 → `weight_adjust`=0 and `fir_go` still pulses.
